// File: rtl/id_ex_operand_stage_pkg.sv
// Shared MIPS pipeline definitions: ALU function codes, register constants, EX control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  // ALU function codes as decoded by ID and consumed by the ALU
  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_A   = 6'b011010,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_LTZ = 6'b111011,
    ALU_GTZ = 6'b111111
  } alufun_e;

  // $zero is hard-wired; it never carries a forwarded value
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Single-bit control held in the EX slot
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic sign;
    logic alusrc_a;
    logic alusrc_b;
  } ctrl_t;

  // A bubble must be inert: no register write and no load, so it never forwards or stalls
  localparam ctrl_t BUBBLE = '{
    valid:    1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    sign:     1'b0,
    alusrc_a: 1'b0,
    alusrc_b: 1'b0
  };

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-to-EX bundle: decoded operands/control from ID plus the load-use freeze back to IF/ID.
// Latency: wires only.
// Backpressure: load_use tells the ID side to hold its slot for one more cycle.
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int FUN_W  = 6
);
  logic              id_valid;
  logic [RA_W-1:0]   id_rs_addr;
  logic [RA_W-1:0]   id_rt_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic              id_alusrc_a;
  logic              id_alusrc_b;
  logic [FUN_W-1:0]  id_alufun;
  logic              id_sign;
  logic [RA_W-1:0]   id_rd_addr;
  logic              id_regwrite;
  logic              id_memread;
  logic              load_use;

  // ID stage side: drives the decoded instruction, observes the freeze
  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_uses_rt,
           id_imm, id_shamt, id_alusrc_a, id_alusrc_b, id_alufun, id_sign,
           id_rd_addr, id_regwrite, id_memread,
    input  load_use
  );

  // ID/EX stage side: consumes the instruction, raises the freeze
  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_uses_rt,
           id_imm, id_shamt, id_alusrc_a, id_alusrc_b, id_alufun, id_sign,
           id_rd_addr, id_regwrite, id_memread,
    output load_use
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forward select: latched register value overridden by EX/MEM, then MEM/WB producers.
// Latency: combinational, 0 cycles.
// Backpressure: none.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic [RA_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_regwrite,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != RA_W'(REG_ZERO)) && (exmem_rd == reg_addr);
  assign hit_memwb = memwb_regwrite && (memwb_rd != RA_W'(REG_ZERO)) && (memwb_rd == reg_addr);

  // Youngest producer wins: EX/MEM is checked before MEM/WB
  always_comb begin
    data = reg_data;
    if (hit_exmem) begin
      data = exmem_result;
    end else if (hit_memwb) begin
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and load-use bubble insertion feeding the ALU.
// Latency: 1 cycle ID->EX register; forwarding into A/B/ex_rt_fwd is combinational.
// Backpressure: stall holds EX (operands refreshed from forwards); load_use freezes IF/ID for a cycle.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int FUN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  id_ex_operand_stage_if.slave id,
  input  logic              exmem_regwrite,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [FUN_W-1:0]  ALUFun,
  output logic              Sign,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread
);

  ctrl_t             ctrl_q;
  logic [FUN_W-1:0]  alufun_q;
  logic [RA_W-1:0]   rd_q;
  logic [RA_W-1:0]   rs_addr_q;
  logic [RA_W-1:0]   rt_addr_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              load_use_int;
  logic              rd_hits_id;

  // A load in EX cannot forward in time to an ID consumer; the consumer must wait one cycle.
  // While stalled or flushed the EX slot is not advancing anyway, so no bubble is needed.
  always_comb begin
    rd_hits_id   = (rd_q == id.id_rs_addr) || (id.id_uses_rt && (rd_q == id.id_rt_addr));
    load_use_int = 1'b0;
    if (id.id_valid && ctrl_q.valid && ctrl_q.memread &&
        (rd_q != RA_W'(REG_ZERO)) && rd_hits_id && !stall && !flush) begin
      load_use_int = 1'b1;
    end
  end

  assign id.load_use = load_use_int;

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .reg_addr       (rs_addr_q),
    .reg_data       (rs_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .data           (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .reg_addr       (rt_addr_q),
    .reg_data       (rt_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .data           (rt_fwd)
  );

  // EX slot update: reset/flush/load-use load a bubble, stall holds but refreshes operands
  // with their forwarded values so a producer leaving MEM/WB during the hold is not lost.
  always_ff @(posedge clk) begin
    if (reset || flush || load_use_int) begin
      ctrl_q    <= BUBBLE;
      alufun_q  <= FUN_W'(ALU_ADD);
      rd_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
    end else if (stall) begin
      rs_q <= rs_fwd;
      rt_q <= rt_fwd;
    end else begin
      ctrl_q.valid    <= id.id_valid;
      ctrl_q.regwrite <= id.id_regwrite;
      ctrl_q.memread  <= id.id_memread;
      ctrl_q.sign     <= id.id_sign;
      ctrl_q.alusrc_a <= id.id_alusrc_a;
      ctrl_q.alusrc_b <= id.id_alusrc_b;
      alufun_q        <= id.id_alufun;
      rd_q            <= id.id_rd_addr;
      rs_addr_q       <= id.id_rs_addr;
      rt_addr_q       <= id.id_rt_addr;
      rs_q            <= id.id_rs_data;
      rt_q            <= id.id_rt_data;
      imm_q           <= id.id_imm;
      shamt_q         <= id.id_shamt;
    end
  end

  // Final operand select; store data always takes the forwarded rt
  assign A           = ctrl_q.alusrc_a ? {{(DATA_W-5){1'b0}}, shamt_q} : rs_fwd;
  assign B           = ctrl_q.alusrc_b ? imm_q : rt_fwd;
  assign ex_rt_fwd   = rt_fwd;
  assign ALUFun      = alufun_q;
  assign Sign        = ctrl_q.sign;
  assign ex_valid    = ctrl_q.valid;
  assign ex_rd       = rd_q;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: scoreboard of expected EX outputs.
// Latency: expected entries pushed when ID is driven, popped after the capturing edge.
// Backpressure: stall/flush/load_use scenarios exercised explicitly.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] A, B, ex_rt_fwd;
  logic [5:0]  ALUFun;
  logic        Sign, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rtf;
    logic [5:0]  fun;
    logic        sign;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  id_ex_operand_stage_if #(.DATA_W(32), .RA_W(5), .FUN_W(6)) idif ();

  id_ex_operand_stage #(.DATA_W(32), .RA_W(5), .FUN_W(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .id             (idif),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .A              (A),
    .B              (B),
    .ALUFun         (ALUFun),
    .Sign           (Sign),
    .ex_rt_fwd      (ex_rt_fwd),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread)
  );

  always #5 clk = ~clk;

  // Stimulus helper: present one decoded instruction on the ID side
  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic ut,
                          input logic [31:0] imm, input logic [4:0] sh, input logic sa,
                          input logic sbit, input logic [5:0] fun, input logic sg,
                          input logic [4:0] rd, input logic rw, input logic mr);
    idif.id_valid    = v;
    idif.id_rs_addr  = rs;
    idif.id_rt_addr  = rt;
    idif.id_rs_data  = rsd;
    idif.id_rt_data  = rtd;
    idif.id_uses_rt  = ut;
    idif.id_imm      = imm;
    idif.id_shamt    = sh;
    idif.id_alusrc_a = sa;
    idif.id_alusrc_b = sbit;
    idif.id_alufun   = fun;
    idif.id_sign     = sg;
    idif.id_rd_addr  = rd;
    idif.id_regwrite = rw;
    idif.id_memread  = mr;
  endtask

  // Stimulus helper: present the two downstream forward sources
  task automatic set_fwd(input logic rw1, input logic [4:0] rd1, input logic [31:0] r1,
                         input logic rw2, input logic [4:0] rd2, input logic [31:0] r2);
    exmem_regwrite = rw1; exmem_rd = rd1; exmem_result = r1;
    memwb_regwrite = rw2; memwb_rd = rd2; memwb_result = r2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rtf,
                      input logic [5:0] fun, input logic sg, input logic v);
    exp_t x;
    x.a = a; x.b = b; x.rtf = rtf; x.fun = fun; x.sign = sg; x.valid = v;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b1, 5'd2, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    drive_id(1'b1, 5'd2, 5'd3, 32'h11, 32'h22, 1'b1, 32'h5, 5'd3, 1'b0, 1'b0,
             6'b000001, 1'b1, 5'd4, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_checks++; if (ALUFun !== 6'b000000) begin n_fail++; $display("FAIL reset_alufun: got %b want 000000", ALUFun); end
    n_checks++; if (A !== 32'd0 || B !== 32'd0) begin n_fail++; $display("FAIL reset_ab: got A=%h B=%h want 0", A, B); end
    n_checks++; if (idif.load_use !== 1'b0) begin n_fail++; $display("FAIL reset_load_use: got %b want 0", idif.load_use); end
    n_checks++; if (ex_regwrite !== 1'b0 || ex_memread !== 1'b0 || Sign !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rw=%b mr=%b sign=%b want 0", ex_regwrite, ex_memread, Sign); end
    reset = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_plain_load();
    drive_id(1'b1, 5'd2, 5'd3, 32'd2, 32'd3, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0,
             6'b000001, 1'b1, 5'd4, 1'b1, 1'b0);
    push(32'd2, 32'd3, 32'd3, 6'b000001, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a) begin n_fail++; $display("FAIL plain_A: got %h want %h", A, e.a); end
    n_checks++; if (B !== e.b) begin n_fail++; $display("FAIL plain_B: got %h want %h", B, e.b); end
    n_checks++; if (ALUFun !== e.fun || Sign !== e.sign) begin
      n_fail++; $display("FAIL plain_fun_sign: got %b/%b want %b/%b", ALUFun, Sign, e.fun, e.sign); end
    n_checks++; if (ex_valid !== e.valid || ex_rd !== 5'd4) begin
      n_fail++; $display("FAIL plain_valid_rd: got %b/%0d want %b/4", ex_valid, ex_rd, e.valid); end
  endtask

  task automatic test_forwarding();
    drive_id(1'b1, 5'd5, 5'd6, 32'h55, 32'h66, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0,
             6'b000000, 1'b0, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    set_fwd(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9);
    push(32'd7, 32'h66, 32'h66, 6'b000000, 1'b0, 1'b1);
    #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a) begin n_fail++; $display("FAIL fwd_exmem_prio_A: got %h want %h", A, e.a); end
    n_checks++; if (B !== e.b) begin n_fail++; $display("FAIL fwd_nomatch_B: got %h want %h", B, e.b); end
    set_fwd(1'b0, 5'd5, 32'd7, 1'b1, 5'd6, 32'd9);
    push(32'h55, 32'd9, 32'd9, 6'b000000, 1'b0, 1'b1);
    #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a || B !== e.b) begin
      n_fail++; $display("FAIL fwd_memwb: got A=%h B=%h want A=%h B=%h", A, B, e.a, e.b); end
    drive_id(1'b1, 5'd0, 5'd6, 32'h55, 32'h66, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0,
             6'b000000, 1'b0, 5'd7, 1'b1, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    set_fwd(1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9);
    push(32'h55, 32'h66, 32'h66, 6'b000000, 1'b0, 1'b1);
    #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a) begin n_fail++; $display("FAIL fwd_reg0_A: got %h want %h", A, e.a); end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd1, 5'd0, 32'h100, 32'h0, 1'b0, 32'h8, 5'd0, 1'b0, 1'b1,
             6'b000000, 1'b0, 5'd8, 1'b1, 1'b1);
    push(32'h100, 32'h8, 32'h0, 6'b000000, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a || B !== e.b || ex_memread !== 1'b1) begin
      n_fail++; $display("FAIL lw_enter: got A=%h B=%h mr=%b want %h %h 1", A, B, ex_memread, e.a, e.b); end
    drive_id(1'b1, 5'd9, 5'd8, 32'h90, 32'hDEAD, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0,
             6'b000001, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    n_checks++; if (idif.load_use !== 1'b0) begin n_fail++; $display("FAIL lu_rt_unused: got %b want 0", idif.load_use); end
    idif.id_uses_rt = 1'b1;
    #1;
    n_checks++; if (idif.load_use !== 1'b1) begin n_fail++; $display("FAIL lu_detect: got %b want 1", idif.load_use); end
    stall = 1'b1;
    #1;
    n_checks++; if (idif.load_use !== 1'b0) begin n_fail++; $display("FAIL lu_stall_mask: got %b want 0", idif.load_use); end
    stall = 1'b0;
    @(posedge clk);
    set_fwd(1'b1, 5'd8, 32'h108, 1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b rw=%b mr=%b want 000", ex_valid, ex_regwrite, ex_memread); end
    n_checks++; if (A !== 32'd0 || idif.load_use !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble_inert: got A=%h lu=%b want 0 0", A, idif.load_use); end
    push(32'h90, 32'hBEEF, 32'hBEEF, 6'b000001, 1'b0, 1'b1);
    @(posedge clk);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hBEEF);
    #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a || B !== e.b || ex_rt_fwd !== e.rtf) begin
      n_fail++; $display("FAIL lu_reenter: got A=%h B=%h rtf=%h want %h %h %h", A, B, ex_rt_fwd, e.a, e.b, e.rtf); end
    n_checks++; if (ex_valid !== e.valid || ALUFun !== e.fun) begin
      n_fail++; $display("FAIL lu_reenter_ctrl: got v=%b fun=%b want %b %b", ex_valid, ALUFun, e.valid, e.fun); end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_stall();
    drive_id(1'b1, 5'd12, 5'd0, 32'h0, 32'h0, 1'b0, 32'h10, 5'd0, 1'b0, 1'b1,
             6'b000000, 1'b0, 5'd13, 1'b1, 1'b0);
    @(posedge clk);
    set_fwd(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'd0);
    push(32'h1234, 32'h10, 32'h0, 6'b000000, 1'b0, 1'b1);
    #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a || B !== e.b) begin
      n_fail++; $display("FAIL stall_start: got A=%h B=%h want %h %h", A, B, e.a, e.b); end
    stall = 1'b1;
    drive_id(1'b1, 5'd3, 5'd3, 32'hFFFF, 32'hFFFF, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0,
             6'b011000, 1'b1, 5'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      if (k == 0) set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1234);
      else        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      push(32'h1234, 32'h10, 32'h0, 6'b000000, 1'b0, 1'b1);
      #1;
      e = sb.pop_front();
      n_checks++; if (A !== e.a || ex_valid !== e.valid || ALUFun !== e.fun) begin
        n_fail++; $display("FAIL stall_hold_%0d: got A=%h v=%b fun=%b want %h %b %b", k, A, ex_valid, ALUFun, e.a, e.valid, e.fun); end
    end
    stall = 1'b0;
    #1;
    n_checks++; if (A !== 32'h1234) begin n_fail++; $display("FAIL stall_release: got A=%h want 1234", A); end
  endtask

  task automatic test_shift_flush();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd0, 5'd14, 32'h0, 32'h77, 1'b1, 32'h0, 5'd4, 1'b1, 1'b0,
             6'b100000, 1'b0, 5'd15, 1'b1, 1'b0);
    push(32'd4, 32'h77, 32'h77, 6'b100000, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_checks++; if (A !== e.a || B !== e.b || ALUFun !== e.fun) begin
      n_fail++; $display("FAIL shift: got A=%h B=%h fun=%b want %h %h %b", A, B, ALUFun, e.a, e.b, e.fun); end
    set_fwd(1'b1, 5'd14, 32'h88, 1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (B !== 32'h88 || ex_rt_fwd !== 32'h88) begin
      n_fail++; $display("FAIL shift_rt_fwd: got B=%h rtf=%h want 88 88", B, ex_rt_fwd); end
    flush = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0;
    n_checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ALUFun !== 6'b000000) begin
      n_fail++; $display("FAIL flush_stall: got v=%b rw=%b fun=%b want 0 0 000000", ex_valid, ex_regwrite, ALUFun); end
    n_checks++; if (A !== 32'd0 || B !== 32'd0) begin
      n_fail++; $display("FAIL flush_data: got A=%h B=%h want 0", A, B); end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  sh;
    logic        sa, sbit, sg;
    logic [5:0]  fun;
    for (int i = 0; i < 6; i++) begin
      rsd = $urandom; rtd = $urandom; imm = $urandom;
      sh = 5'($urandom_range(0, 31)); fun = 6'($urandom_range(0, 63));
      sa = 1'($urandom_range(0, 1)); sbit = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      drive_id(1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), rsd, rtd, 1'b1, imm, sh,
               sa, sbit, fun, sg, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
      push(sa ? {27'd0, sh} : rsd, sbit ? imm : rtd, rtd, fun, sg, 1'b1);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++; if (A !== e.a || B !== e.b || ex_rt_fwd !== e.rtf) begin
        n_fail++; $display("FAIL b2b_%0d_data: got A=%h B=%h rtf=%h want %h %h %h", i, A, B, ex_rt_fwd, e.a, e.b, e.rtf); end
      n_checks++; if (ALUFun !== e.fun || Sign !== e.sign || ex_valid !== e.valid) begin
        n_fail++; $display("FAIL b2b_%0d_ctrl: got fun=%b s=%b v=%b want %b %b %b", i, ALUFun, Sign, ex_valid, e.fun, e.sign, e.valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plain_load();
    test_forwarding();
    test_load_use();
    test_stall();
    test_shift_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
